// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
//   Bundle of every non-clock/reset signal that crosses the Memory stage
//   boundary. I_* signals come from the Execute output latch, O_* signals go
//   to Writeback, the front-end stall network, and the board I/O.
//
//   Modports:
//     master : driver side (Execute / bench); drives I_*, observes O_*
//     slave  : the memory_access stage; observes I_*, drives O_*
//
//   Pipeline-wide width and opcode macros are defined here with guards so a
//   project-level header may override them.
// -----------------------------------------------------------------------------
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OP_LDW
`define OP_LDW 8'h10
`endif
`ifndef OP_LDB
`define OP_LDB 8'h11
`endif
`ifndef OP_STW
`define OP_STW 8'h12
`endif
`ifndef OP_STB
`define OP_STB 8'h13
`endif

interface memory_access_if;
  // From Execute
  logic                     I_LOCK;
  logic [`PC_WIDTH-1:0]     I_PC;
  logic [`OPCODE_WIDTH-1:0] I_Opcode;
  logic [`IR_WIDTH-1:0]     I_IR;
  logic [3:0]               I_DestRegIdx;
  logic [`REG_WIDTH-1:0]    I_DestValue;
  logic [2:0]               I_CCValue;
  logic [`REG_WIDTH-1:0]    I_MARValue;
  logic [`REG_WIDTH-1:0]    I_MDRValue;
  logic                     I_EX_Valid;
  logic                     I_RegWEn;
  logic                     I_CCWEn;

  // To Writeback / front-end / board
  logic                     O_LOCK;
  logic [`PC_WIDTH-1:0]     O_PC;
  logic [`OPCODE_WIDTH-1:0] O_Opcode;
  logic [`IR_WIDTH-1:0]     O_IR;
  logic [3:0]               O_DestRegIdx;
  logic [`REG_WIDTH-1:0]    O_DestValue;
  logic [2:0]               O_CCValue;
  logic                     O_MEM_Valid;
  logic                     O_RegWEn;
  logic                     O_CCWEn;
  logic                     O_MemStallSignal;
  logic                     O_RegWEn_Signal;
  logic [9:0]               O_LEDR;
  logic [15:0]              O_HEX;

  modport master (
    output I_LOCK, I_PC, I_Opcode, I_IR, I_DestRegIdx, I_DestValue, I_CCValue,
           I_MARValue, I_MDRValue, I_EX_Valid, I_RegWEn, I_CCWEn,
    input  O_LOCK, O_PC, O_Opcode, O_IR, O_DestRegIdx, O_DestValue, O_CCValue,
           O_MEM_Valid, O_RegWEn, O_CCWEn, O_MemStallSignal, O_RegWEn_Signal,
           O_LEDR, O_HEX
  );

  modport slave (
    input  I_LOCK, I_PC, I_Opcode, I_IR, I_DestRegIdx, I_DestValue, I_CCValue,
           I_MARValue, I_MDRValue, I_EX_Valid, I_RegWEn, I_CCWEn,
    output O_LOCK, O_PC, O_Opcode, O_IR, O_DestRegIdx, O_DestValue, O_CCValue,
           O_MEM_Valid, O_RegWEn, O_CCWEn, O_MemStallSignal, O_RegWEn_Signal,
           O_LEDR, O_HEX
  );
endinterface

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//   Pipeline stage between Execute and Writeback. Performs LDW/LDB/STW/STB on
//   a word-organised 16-bit data memory with a MEM_LATENCY-cycle occupancy,
//   stalling upstream and emitting bubbles while an access is in flight.
//   Non-memory instructions pass through in one cycle. All state updates on
//   the I_CLOCK negedge, like the other pipeline stages.
//
//   Parameters:
//     DMEM_ADDR_BITS : word-address bits (2^DMEM_ADDR_BITS 16-bit words)
//     MEM_LATENCY    : cycles a memory op occupies the stage, 1..15
//
//   Ports:
//     I_CLOCK   : stage clock (negedge active)
//     I_RESET_N : synchronous active-low reset, sampled on the negedge
//     bus       : memory_access_if.slave -- Execute latch in, Writeback
//                 latch out, stall/dependency strobes, LEDR/HEX registers
//
//   Build option:
//     MEM_IO_EN : when defined, stores to byte address 0xFFF0 / 0xFFF2 write
//                 the LEDR / HEX registers instead of memory and loads from
//                 them read those registers back. When undefined those
//                 addresses wrap into memory and O_LEDR / O_HEX are 0.
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int DMEM_ADDR_BITS = 10,
  parameter int MEM_LATENCY    = 2
) (
  input  logic           I_CLOCK,
  input  logic           I_RESET_N,
  memory_access_if.slave bus
);

  localparam int         WORDS    = 1 << DMEM_ADDR_BITS;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Writeback-facing output latch
  typedef struct packed {
    logic [`PC_WIDTH-1:0]     pc;
    logic [`OPCODE_WIDTH-1:0] opcode;
    logic [`IR_WIDTH-1:0]     ir;
    logic [3:0]               dest_idx;
    logic [`REG_WIDTH-1:0]    dest_value;
    logic [2:0]               cc_value;
    logic                     mem_valid;
    logic                     reg_wen;
    logic                     cc_wen;
  } out_latch_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  out_latch_t out_q, out_d;
  logic       lock_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic is_ldb, is_stb, is_load, is_store, memop;
  logic at_last, stall, complete;

  assign is_ldb   = bus.I_EX_Valid && (bus.I_Opcode == `OP_LDB);
  assign is_stb   = bus.I_EX_Valid && (bus.I_Opcode == `OP_STB);
  assign is_load  = is_ldb || (bus.I_EX_Valid && (bus.I_Opcode == `OP_LDW));
  assign is_store = is_stb || (bus.I_EX_Valid && (bus.I_Opcode == `OP_STW));
  assign memop    = is_load || is_store;

  // The final cycle of an access is the one where cnt has reached LAST_CNT;
  // with MEM_LATENCY = 1 that is cnt = 0, so the stall never rises.
  assign at_last  = (cnt_q == LAST_CNT);
  assign complete = memop && at_last && !bus.I_LOCK;

  // ---------------------------------------------------------------------------
  // Data memory and I/O registers
  // ---------------------------------------------------------------------------
  logic [DMEM_ADDR_BITS-1:0] idx;
  logic                      lane_hi;
  logic [15:0]               mem [WORDS];
  logic [15:0]               word_rd, load_data, store_word;
  logic                      io_sel, mem_we;
  logic [15:0]               io_rdata;

  // Byte address -> word index; bits above the index simply wrap.
  assign idx     = bus.I_MARValue[DMEM_ADDR_BITS:1];
  assign lane_hi = bus.I_MARValue[0];

  // Address bits above the word index only matter for I/O decode.
  logic unused_mar;
  assign unused_mar = ^bus.I_MARValue[`REG_WIDTH-1:DMEM_ADDR_BITS+1];

`ifdef MEM_IO_EN
  logic       sel_ledr, sel_hex;
  logic [9:0] ledr_q;
  logic [15:0] hex_q;

  assign sel_ledr = (bus.I_MARValue == 16'hFFF0);
  assign sel_hex  = (bus.I_MARValue == 16'hFFF2);
  assign io_sel   = sel_ledr || sel_hex;
  assign io_rdata = sel_ledr ? {6'b0, ledr_q} : hex_q;

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      ledr_q <= '0;
      hex_q  <= '0;
    end else if (complete && is_store) begin
      if (sel_ledr) ledr_q <= bus.I_MDRValue[9:0];
      if (sel_hex)  hex_q  <= bus.I_MDRValue[15:0];
    end
  end

  assign bus.O_LEDR = ledr_q;
  assign bus.O_HEX  = hex_q;
`else
  assign io_sel     = 1'b0;
  assign io_rdata   = 16'h0000;
  assign bus.O_LEDR = '0;
  assign bus.O_HEX  = '0;
`endif

  // Read happens at the completion edge, so any store completed earlier is
  // already in the array.
  assign word_rd = mem[idx];

  assign load_data = io_sel ? io_rdata :
                     is_ldb ? {8'h00, (lane_hi ? word_rd[15:8] : word_rd[7:0])} :
                              word_rd;

  // Byte stores merge the untouched lane back in (read-modify-write).
  assign store_word = !is_stb ? bus.I_MDRValue :
                      lane_hi ? {bus.I_MDRValue[7:0], word_rd[7:0]} :
                                {word_rd[15:8], bus.I_MDRValue[7:0]};

  // Reset gates the write so an access interrupted by reset is dropped.
  assign mem_we = complete && is_store && !io_sel && I_RESET_N;

  // NOTE: the array has no reset branch; contents survive reset by design and
  // a reset loop over every word would prevent mapping to RAM.
  always_ff @(negedge I_CLOCK) begin
    if (mem_we) mem[idx] <= store_word;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use <= only, so every flop samples pre-edge values
  // regardless of block ordering.
  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.I_LOCK) begin
      unique case (state_q)
        IDLE: begin
          if (memop && !at_last) begin
            state_d = BUSY;
            cnt_d   = 4'd1;
          end else begin
            cnt_d   = '0;
          end
        end
        BUSY: begin
          if (memop && !at_last) begin
            cnt_d   = cnt_q + 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (stall strobes and next output-latch contents)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d = out_q;
    stall = memop && !at_last && !bus.I_LOCK;
    if (!bus.I_LOCK) begin
      out_d.pc         = bus.I_PC;
      out_d.opcode     = bus.I_Opcode;
      out_d.ir         = bus.I_IR;
      out_d.dest_idx   = bus.I_DestRegIdx;
      out_d.cc_value   = bus.I_CCValue;
      out_d.dest_value = is_load ? load_data : bus.I_DestValue;
      out_d.mem_valid  = bus.I_EX_Valid;
      out_d.reg_wen    = is_load ? 1'b1 : (is_store ? 1'b0 : bus.I_RegWEn);
      out_d.cc_wen     = is_store ? 1'b0 : bus.I_CCWEn;
      if (stall) begin
        // Bubble: the access is still in flight.
        out_d.dest_value = bus.I_DestValue;
        out_d.mem_valid  = 1'b0;
        out_d.reg_wen    = 1'b0;
        out_d.cc_wen     = 1'b0;
      end
    end
  end

  // Output latch; reset takes priority over I_LOCK.
  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      out_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      lock_q <= bus.I_LOCK;
    end
  end

  assign bus.O_LOCK           = lock_q;
  assign bus.O_PC             = out_q.pc;
  assign bus.O_Opcode         = out_q.opcode;
  assign bus.O_IR             = out_q.ir;
  assign bus.O_DestRegIdx     = out_q.dest_idx;
  assign bus.O_DestValue      = out_q.dest_value;
  assign bus.O_CCValue        = out_q.cc_value;
  assign bus.O_MEM_Valid      = out_q.mem_valid;
  assign bus.O_RegWEn         = out_q.reg_wen;
  assign bus.O_CCWEn          = out_q.cc_wen;
  assign bus.O_MemStallSignal = stall;
  assign bus.O_RegWEn_Signal  = bus.I_RegWEn & bus.I_EX_Valid;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//   Self-checking bench for memory_access. Reference memory is a flat
//   little-endian byte array; word and byte accesses are derived from it.
//   Inputs change just after posedge, DUT updates on negedge, outputs are
//   sampled at the following posedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef OP_LDW
`define OP_LDW 8'h10
`endif
`ifndef OP_LDB
`define OP_LDB 8'h11
`endif
`ifndef OP_STW
`define OP_STW 8'h12
`endif
`ifndef OP_STB
`define OP_STB 8'h13
`endif

module tb_memory_access;
  localparam int         AW     = 10;
  localparam int         LAT    = 2;
  localparam int         NBYTES = 2 ** (AW + 1);
  localparam logic [7:0] OP_ADD = 8'h01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_access_if bus ();

  memory_access #(.DMEM_ADDR_BITS(AW), .MEM_LATENCY(LAT)) dut (
    .I_CLOCK  (clk),
    .I_RESET_N(rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_bytes [NBYTES];
  logic [9:0]  ref_ledr = '0;
  logic [15:0] ref_hex  = '0;

  function automatic int baddr(input logic [15:0] a);
    return int'(a) % NBYTES;
  endfunction

  function automatic logic [15:0] ref_load(input logic [7:0] op, input logic [15:0] mar);
    int b;
    int w;
    b = baddr(mar);
    w = b - (b % 2);
`ifdef MEM_IO_EN
    if (mar == 16'hFFF0) return {6'b0, ref_ledr};
    if (mar == 16'hFFF2) return ref_hex;
`endif
    if (op == `OP_LDB) return {8'h00, ref_bytes[b]};
    return {ref_bytes[w + 1], ref_bytes[w]};
  endfunction

  task automatic ref_store(input logic [7:0] op, input logic [15:0] mar, input logic [15:0] mdr);
    int b;
    int w;
    b = baddr(mar);
    w = b - (b % 2);
`ifdef MEM_IO_EN
    if (mar == 16'hFFF0) begin ref_ledr = mdr[9:0]; return; end
    if (mar == 16'hFFF2) begin ref_hex = mdr; return; end
`endif
    if (op == `OP_STB) ref_bytes[b] = mdr[7:0];
    else begin
      ref_bytes[w]     = mdr[7:0];
      ref_bytes[w + 1] = mdr[15:8];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] op, input logic valid, input logic [15:0] mar,
                       input logic [15:0] mdr, input logic [15:0] dv, input logic lock);
    bus.I_LOCK       = lock;
    bus.I_PC         = 16'($urandom);
    bus.I_Opcode     = op;
    bus.I_IR         = $urandom;
    bus.I_DestRegIdx = 4'($urandom);
    bus.I_DestValue  = dv;
    bus.I_CCValue    = 3'($urandom);
    bus.I_MARValue   = mar;
    bus.I_MDRValue   = mdr;
    bus.I_EX_Valid   = valid;
    bus.I_RegWEn     = 1'($urandom);
    bus.I_CCWEn      = 1'($urandom);
  endtask

  // One full instruction; entered just after a posedge, returns at a posedge.
  task automatic do_op(input string tag, input logic [7:0] op, input logic valid,
                       input logic [15:0] mar, input logic [15:0] mdr,
                       input logic [15:0] dv, output logic [15:0] got);
    logic is_ld, is_st, exp_rwe, exp_cwe;
    logic [15:0] exp_dv, pc;
    logic [3:0] didx;
    int cycles;
    drive(op, valid, mar, mdr, dv, 1'b0);
    is_ld   = valid && (op == `OP_LDW || op == `OP_LDB);
    is_st   = valid && (op == `OP_STW || op == `OP_STB);
    cycles  = (is_ld || is_st) ? LAT : 1;
    exp_dv  = is_ld ? ref_load(op, mar) : dv;
    exp_rwe = is_ld ? 1'b1 : (is_st ? 1'b0 : bus.I_RegWEn);
    exp_cwe = is_st ? 1'b0 : bus.I_CCWEn;
    pc      = bus.I_PC;
    didx    = bus.I_DestRegIdx;
    for (int k = 0; k < cycles; k++) begin
      #1;
      if (k == 0) check({tag, " regwen_sig"}, bus.O_RegWEn_Signal, bus.I_RegWEn & valid);
      check({tag, " stall"}, bus.O_MemStallSignal, (k < cycles - 1));
      @(negedge clk);
      @(posedge clk);
      if (k < cycles - 1) begin
        check({tag, " bubble valid"}, bus.O_MEM_Valid, 0);
        check({tag, " bubble regwen"}, bus.O_RegWEn, 0);
      end
    end
    check({tag, " valid"}, bus.O_MEM_Valid, valid);
    check({tag, " dest"}, bus.O_DestValue, exp_dv);
    check({tag, " regwen"}, bus.O_RegWEn, exp_rwe);
    check({tag, " ccwen"}, bus.O_CCWEn, exp_cwe);
    check({tag, " pc"}, bus.O_PC, pc);
    check({tag, " didx"}, bus.O_DestRegIdx, didx);
    if (is_st) ref_store(op, mar, mdr);
    got = bus.O_DestValue;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] got;
    logic [15:0] exp_v;
    logic [7:0]  ops [5];
    logic [15:0] hi_masks [3];
    ops[0] = `OP_LDW; ops[1] = `OP_LDB; ops[2] = `OP_STW; ops[3] = `OP_STB; ops[4] = OP_ADD;
    hi_masks[0] = 16'h0000; hi_masks[1] = 16'h0800; hi_masks[2] = 16'hF800;

    // Reset for 2 edges with random inputs; I_LOCK=1 shows reset wins.
    drive(8'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    check("rst lock", bus.O_LOCK, 0);
    check("rst pc", bus.O_PC, 0);
    check("rst opcode", bus.O_Opcode, 0);
    check("rst ir", bus.O_IR, 0);
    check("rst didx", bus.O_DestRegIdx, 0);
    check("rst dest", bus.O_DestValue, 0);
    check("rst cc", bus.O_CCValue, 0);
    check("rst valid", bus.O_MEM_Valid, 0);
    check("rst regwen", bus.O_RegWEn, 0);
    check("rst ccwen", bus.O_CCWEn, 0);
    check("rst ledr", bus.O_LEDR, 0);
    check("rst hex", bus.O_HEX, 0);
    check("rst stall", bus.O_MemStallSignal, 0);
    rst_n = 1'b1;

    // Preload the test region so every later load has a defined value.
    for (int i = 0; i < 64; i += 2)
      do_op("preload", `OP_STW, 1'b1, 16'(i), 16'($urandom), 16'($urandom), got);

    // Word store/load round trip.
    do_op("stw 0010", `OP_STW, 1'b1, 16'h0010, 16'hBEEF, 16'h1111, got);
    do_op("ldw 0010", `OP_LDW, 1'b1, 16'h0010, 16'h0000, 16'h2222, got);
    check("ldw beef", got, 16'hBEEF);

    // Byte lanes.
    do_op("stb 0011", `OP_STB, 1'b1, 16'h0011, 16'h12A5, 16'h3333, got);
    do_op("ldw 0010b", `OP_LDW, 1'b1, 16'h0010, 16'h0000, 16'h4444, got);
    check("ldw a5ef", got, 16'hA5EF);
    do_op("ldb 0011", `OP_LDB, 1'b1, 16'h0011, 16'h0000, 16'h5555, got);
    check("ldb 00a5", got, 16'h00A5);
    do_op("ldb 0010", `OP_LDB, 1'b1, 16'h0010, 16'h0000, 16'h5555, got);
    check("ldb 00ef", got, 16'h00EF);

    // Pass-through.
    do_op("add", OP_ADD, 1'b1, 16'h0010, 16'h0000, 16'h0007, got);
    check("add 0007", got, 16'h0007);

    // Lock held mid-access freezes the stage.
    exp_v = ref_load(`OP_LDW, 16'h0010);
    drive(`OP_LDW, 1'b1, 16'h0010, 16'h0000, 16'h6666, 1'b0);
    #1 check("lock stall0", bus.O_MemStallSignal, 1);
    @(negedge clk); @(posedge clk);
    check("lock bubble", bus.O_MEM_Valid, 0);
    bus.I_LOCK = 1'b1;
    #1 check("lock stall off", bus.O_MemStallSignal, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); @(posedge clk);
      check("lock olock", bus.O_LOCK, 1);
      check("lock held valid", bus.O_MEM_Valid, 0);
      check("lock held dest", bus.O_DestValue, 16'h6666);
    end
    bus.I_LOCK = 1'b0;
    #1 check("unlock stall", bus.O_MemStallSignal, 0);
    @(negedge clk); @(posedge clk);
    check("unlock valid", bus.O_MEM_Valid, 1);
    check("unlock dest", bus.O_DestValue, exp_v);
    check("unlock olock", bus.O_LOCK, 0);

    // Reset during an in-flight store drops the store.
    do_op("stw 0020", `OP_STW, 1'b1, 16'h0020, 16'hC0DE, 16'h0000, got);
    drive(`OP_STW, 1'b1, 16'h0020, 16'hDEAD, 16'h0000, 1'b0);
    @(negedge clk); @(posedge clk);
    rst_n = 1'b0;
    @(negedge clk); @(posedge clk);
    check("midrst valid", bus.O_MEM_Valid, 0);
    check("midrst pc", bus.O_PC, 0);
    drive(OP_ADD, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    do_op("ldw 0020", `OP_LDW, 1'b1, 16'h0020, 16'h0000, 16'h0000, got);
    check("ldw c0de", got, 16'hC0DE);

    // Memory-mapped I/O.
    do_op("stw fff0", `OP_STW, 1'b1, 16'hFFF0, 16'h03FF, 16'h0000, got);
`ifdef MEM_IO_EN
    check("ledr set", bus.O_LEDR, 10'h3FF);
    do_op("stw fff2", `OP_STW, 1'b1, 16'hFFF2, 16'h1234, 16'h0000, got);
    check("hex set", bus.O_HEX, 16'h1234);
`else
    check("ledr tied", bus.O_LEDR, 0);
    check("hex tied", bus.O_HEX, 0);
`endif
    do_op("ldw fff0", `OP_LDW, 1'b1, 16'hFFF0, 16'h0000, 16'h0000, got);
    check("ldw fff0 03ff", got, 16'h03FF);

    // Randomised mix over the preloaded region, including aliased addresses.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] mar;
      mar = 16'($urandom_range(0, 63)) | hi_masks[$urandom_range(0, 2)];
      do_op("rand", ops[$urandom_range(0, 4)], ($urandom_range(0, 7) != 0),
            mar, 16'($urandom), 16'($urandom), got);
    end

    drive(OP_ADD, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk); @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
